// File: rtl/uart_link_tester_pkg.sv
// Shared definitions for the UART link self-test master: pattern mode codes,
// FSM state encodings and the LFSR feedback taps.
package uart_link_tester_pkg;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_FIXED = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;  // behaves as MODE_INC

    // Fibonacci x^8+x^6+x^5+x^4+1, shift left: feedback = q[7]^q[5]^q[4]^q[3]
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_ECHO  = 3'd4,
        ST_CHECK = 3'd5,
        ST_TMO   = 3'd6,
        ST_FAULT = 3'd7
    } state_t;

    // The tester reports busy everywhere except the two resting states.
    function automatic logic state_is_busy(input state_t s);
        return !((s == ST_IDLE) || (s == ST_FAULT));
    endfunction

endpackage

// File: rtl/uart_link_tester_if.sv
// Connection between the link tester (master) and the uart_tx/uart_rx pair (slave).
//
// Handshake: start_tx is a request held high until the transmitter answers with
// tx_busy=1; data_to_tx is stable for the whole time start_tx is high and until
// the byte is resolved. rx_done is a one-cycle valid strobe with no ready: the
// tester must accept data_received/parity_error in the cycle rx_done is high.
interface uart_link_tester_if #(
    parameter int DATA_W = 8
);
    logic              start_tx;
    logic [DATA_W-1:0] data_to_tx;
    logic              tx_busy;
    logic              rx_done;
    logic [DATA_W-1:0] data_received;
    logic              parity_error;

    modport master (
        output start_tx, data_to_tx,
        input  tx_busy, rx_done, data_received, parity_error
    );

    modport slave (
        input  start_tx, data_to_tx,
        output tx_busy, rx_done, data_received, parity_error
    );
endinterface

// File: rtl/uart_link_tester_pattern_gen.sv
// Test byte source: increment counter, fixed byte or 8-bit LFSR. The byte is
// presented combinationally from the selected source; advance_i steps only the
// register belonging to the currently selected mode.
module uart_link_tester_pattern_gen
    import uart_link_tester_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] fixed_pattern_i,
    input  logic              advance_i,
    output logic [DATA_W-1:0] pattern_o
);

    localparam logic [DATA_W-1:0] TAPS = DATA_W'(LFSR_TAPS);

    logic [DATA_W-1:0] inc_q, inc_d;
    logic [DATA_W-1:0] lfsr_q, lfsr_d;

    // Next-state of the pattern registers on an advance strobe.
    always_comb begin
        inc_d  = inc_q;
        lfsr_d = lfsr_q;
        if (advance_i) begin
            case (mode_i)
                MODE_FIXED: ;
                MODE_LFSR:  lfsr_d = {lfsr_q[DATA_W-2:0], ^(lfsr_q & TAPS)};
                default:    inc_d  = inc_q + DATA_W'(1);
            endcase
        end
    end

    // Pattern registers; the LFSR seeds at 1 so it never reaches the all-zero lock-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_q  <= '0;
            lfsr_q <= DATA_W'(1);
        end else begin
            inc_q  <= inc_d;
            lfsr_q <= lfsr_d;
        end
    end

    // Byte selection follows the live mode, so a mode change is picked up at the next LOAD.
    always_comb begin
        case (mode_i)
            MODE_FIXED: pattern_o = fixed_pattern_i;
            MODE_LFSR:  pattern_o = lfsr_q;
            default:    pattern_o = inc_q;
        endcase
    end

endmodule

// File: rtl/uart_link_tester.sv
// UART link self-test master: sends FRAME_LEN-byte frames, checks each echoed
// byte, retries on timeout and keeps saturating frame/error/timeout counters.
module uart_link_tester
    import uart_link_tester_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int FRAME_LEN      = 4,         // >= 1
    parameter int START_DELAY    = 48000000,  // >= 1
    parameter int TIMEOUT_CYCLES = 480,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [DATA_W-1:0]   fixed_pattern,
    uart_link_tester_if.master  uart,
    output logic                busy,
    output logic                link_ok,
    output logic                fault,
    output logic [CNT_W-1:0]    frame_count,
    output logic [CNT_W-1:0]    error_count,
    output logic [CNT_W-1:0]    timeout_count,
    output logic [2:0]          dbg_state
);

    localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DELAY - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    state_t            state_q;
    logic [DLY_W-1:0]  delay_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [RTY_W-1:0]  retry_q;
    logic [IDX_W-1:0]  byte_idx_q;
    logic              frame_clean_q;
    logic              start_tx_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_par_q;
    logic              link_ok_q;
    logic [CNT_W-1:0]  frame_q;
    logic [CNT_W-1:0]  error_q;
    logic [CNT_W-1:0]  timeout_q;

    logic [DATA_W-1:0] pattern;
    logic              byte_bad;

    uart_link_tester_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .clk             (clk),
        .reset           (reset),
        .mode_i          (mode),
        .fixed_pattern_i (fixed_pattern),
        .advance_i       (state_q == ST_CHECK),
        .pattern_o       (pattern)
    );

    assign byte_bad = (rx_data_q != data_q) || rx_par_q;

    // Main sequencer: delay, load, start handshake, echo wait, check, timeout/retry and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            delay_q       <= '0;
            tmo_q         <= '0;
            retry_q       <= '0;
            byte_idx_q    <= '0;
            frame_clean_q <= 1'b0;
            start_tx_q    <= 1'b0;
            data_q        <= '0;
            rx_data_q     <= '0;
            rx_par_q      <= 1'b0;
            link_ok_q     <= 1'b0;
            frame_q       <= '0;
            error_q       <= '0;
            timeout_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    byte_idx_q <= '0;
                    retry_q    <= '0;
                    if (enable) begin
                        delay_q <= '0;
                        state_q <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end else if (delay_q == DLY_LAST) begin
                        state_q <= ST_LOAD;
                    end else begin
                        delay_q <= delay_q + DLY_W'(1);
                    end
                end
                ST_LOAD: begin
                    data_q     <= pattern;
                    tmo_q      <= '0;
                    start_tx_q <= 1'b1;
                    state_q    <= ST_START;
                    if (byte_idx_q == '0) begin
                        frame_clean_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (uart.tx_busy) begin
                        start_tx_q <= 1'b0;
                        tmo_q      <= '0;
                        state_q    <= ST_ECHO;
                    end else if (tmo_q == TMO_MAX) begin
                        start_tx_q <= 1'b0;
                        state_q    <= ST_TMO;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_ECHO: begin
                    // An echo arriving on the timeout cycle still counts as an echo.
                    if (uart.rx_done) begin
                        rx_data_q <= uart.data_received;
                        rx_par_q  <= uart.parity_error;
                        state_q   <= ST_CHECK;
                    end else if (tmo_q == TMO_MAX) begin
                        state_q <= ST_TMO;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_CHECK: begin
                    retry_q <= '0;
                    if (byte_bad) begin
                        if (error_q != '1) error_q <= error_q + CNT_W'(1);
                        link_ok_q     <= 1'b0;
                        frame_clean_q <= 1'b0;
                    end
                    if (byte_idx_q == IDX_LAST) begin
                        if (frame_q != '1) frame_q <= frame_q + CNT_W'(1);
                        link_ok_q  <= frame_clean_q && !byte_bad;
                        byte_idx_q <= '0;
                    end else begin
                        byte_idx_q <= byte_idx_q + IDX_W'(1);
                    end
                    state_q <= enable ? ST_LOAD : ST_IDLE;
                end
                ST_TMO: begin
                    if (timeout_q != '1) timeout_q <= timeout_q + CNT_W'(1);
                    link_ok_q     <= 1'b0;
                    frame_clean_q <= 1'b0;
                    if (retry_q >= RTY_MAX) begin
                        state_q <= ST_FAULT;
                    end else if (!enable) begin
                        state_q <= ST_IDLE;
                    end else begin
                        // data_q is untouched, so the same byte goes out again.
                        retry_q    <= retry_q + RTY_W'(1);
                        tmo_q      <= '0;
                        start_tx_q <= 1'b1;
                        state_q    <= ST_START;
                    end
                end
                ST_FAULT: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign uart.start_tx   = start_tx_q;
    assign uart.data_to_tx = data_q;
    assign busy            = state_is_busy(state_q);
    assign fault           = (state_q == ST_FAULT);
    assign link_ok         = link_ok_q;
    assign frame_count     = frame_q;
    assign error_count     = error_q;
    assign timeout_count   = timeout_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_uart_link_tester.sv
// Directed bench for uart_link_tester with a behavioural uart_tx/uart_rx loopback.
module tb_uart_link_tester;
  import uart_link_tester_pkg::*;

  localparam int DW = 8;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] fixed_pattern = 8'hA5;
  logic          busy, link_ok, fault;
  logic [CW-1:0] frame_count, error_count, timeout_count;
  logic [2:0]    dbg_state;

  uart_link_tester_if #(.DATA_W(DW)) uif ();

  uart_link_tester #(
    .DATA_W         (DW),
    .FRAME_LEN      (4),
    .START_DELAY    (10),
    .TIMEOUT_CYCLES (600),
    .MAX_RETRIES    (3),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .mode          (mode),
    .fixed_pattern (fixed_pattern),
    .uart          (uif),
    .busy          (busy),
    .link_ok       (link_ok),
    .fault         (fault),
    .frame_count   (frame_count),
    .error_count   (error_count),
    .timeout_count (timeout_count),
    .dbg_state     (dbg_state)
  );

  // ---------------- loopback model controls and scoreboard ----------------
  int att_cnt = 0;       // attempts seen since last arm
  int corrupt_att = -1;  // attempt whose echo becomes 8'h55
  int sup_lo = -1;       // attempts in [sup_lo, sup_hi] get no echo
  int sup_hi = -1;
  bit sup_all = 1'b0;
  logic [DW-1:0] sent_q[$];
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  // uart_tx/uart_rx model: busy for 8 cycles after a start, echo 3 cycles later.
  initial begin : uart_model
    logic [DW-1:0] b;
    int a;
    bit drop;
    uif.tx_busy = 1'b0;
    uif.rx_done = 1'b0;
    uif.data_received = '0;
    uif.parity_error = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (uif.start_tx) begin
        b = uif.data_to_tx;
        a = att_cnt;
        att_cnt++;
        sent_q.push_back(b);
        uif.tx_busy = 1'b1;
        repeat (8) @(posedge clk);
        #1 uif.tx_busy = 1'b0;
        drop = sup_all || (a >= sup_lo && a <= sup_hi);
        if (!drop) begin
          repeat (3) @(posedge clk);
          #1;
          uif.data_received = (a == corrupt_att) ? 8'h55 : b;
          uif.rx_done = 1'b1;
          @(posedge clk);
          #1 uif.rx_done = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int c;
    c = 0;
    while (int'(frame_count) < target && c < budget) begin
      tick();
      c++;
    end
    check("frame_count_reached", 32'(frame_count), 32'(target));
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget);
    int c;
    c = 0;
    while (dbg_state != st && c < budget) begin
      tick();
      c++;
    end
    check("state_reached", 32'(dbg_state), 32'(st));
  endtask

  task automatic wait_sent(input int n, input int budget);
    int c;
    c = 0;
    while (sent_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    check("bytes_sent", 32'(sent_q.size() >= n), 32'(1));
  endtask

  task automatic compare_sent(input string tag);
    logic [DW-1:0] e, s;
    check({tag, "_count"}, 32'(sent_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = (sent_q.size() > 0) ? sent_q.pop_front() : {DW{1'bx}};
      check(tag, 32'(s), 32'(e));
    end
    sent_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_fault"}, 32'(fault), 32'(0));
    check({tag, "_link_ok"}, 32'(link_ok), 32'(0));
    check({tag, "_start_tx"}, 32'(uif.start_tx), 32'(0));
    check({tag, "_data_to_tx"}, 32'(uif.data_to_tx), 32'(0));
    check({tag, "_frames"}, 32'(frame_count), 32'(0));
    check({tag, "_errors"}, 32'(error_count), 32'(0));
    check({tag, "_timeouts"}, 32'(timeout_count), 32'(0));
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) tick();
    check_all_zero("post_reset_idle");

    // 1: increment pattern, three frames, then stop (one extra byte completes)
    mode = 2'd0;
    enable = 1'b1;
    wait_frames(3, 1000);
    enable = 1'b0;
    wait_state(ST_IDLE, 200);
    check("t1_frames", 32'(frame_count), 32'(3));
    check("t1_errors", 32'(error_count), 32'(0));
    check("t1_link_ok", 32'(link_ok), 32'(1));
    for (int i = 0; i <= 12; i++) exp_q.push_back(DW'(i));
    compare_sent("t1_byte");

    // 2: LFSR pattern, two frames plus the byte in flight when stopping
    mode = 2'd2;
    enable = 1'b1;
    wait_frames(5, 1000);
    enable = 1'b0;
    wait_state(ST_IDLE, 200);
    check("t2_errors", 32'(error_count), 32'(0));
    check("t2_link_ok", 32'(link_ok), 32'(1));
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
    compare_sent("t2_byte");

    // 3: corrupt echo of byte 2, then a clean frame
    mode = 2'd0;
    att_cnt = 0;
    corrupt_att = 2;
    enable = 1'b1;
    wait_frames(6, 1000);
    check("t3_errors_dirty", 32'(error_count), 32'(1));
    check("t3_link_ok_dirty", 32'(link_ok), 32'(0));
    wait_frames(7, 1000);
    check("t3_link_ok_clean", 32'(link_ok), 32'(1));
    check("t3_errors_clean", 32'(error_count), 32'(1));
    enable = 1'b0;
    wait_state(ST_IDLE, 200);
    corrupt_att = -1;
    for (int i = 8'h0D; i <= 8'h15; i++) exp_q.push_back(DW'(i));
    compare_sent("t3_byte");

    // 4: byte 1 echo suppressed twice, third attempt succeeds
    att_cnt = 0;
    sup_lo = 1;
    sup_hi = 2;
    enable = 1'b1;
    wait_frames(8, 3000);
    check("t4_timeouts", 32'(timeout_count), 32'(2));
    check("t4_errors", 32'(error_count), 32'(1));
    enable = 1'b0;
    wait_state(ST_IDLE, 200);
    sup_lo = -1;
    sup_hi = -1;
    exp_q = '{8'h16, 8'h17, 8'h17, 8'h17, 8'h18, 8'h19, 8'h1A};
    compare_sent("t4_byte");

    // 5: echo cut permanently -> four timeouts then FAULT
    sup_all = 1'b1;
    enable = 1'b1;
    wait_state(ST_FAULT, 4000);
    check("t5_fault", 32'(fault), 32'(1));
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_link_ok", 32'(link_ok), 32'(0));
    check("t5_start_tx", 32'(uif.start_tx), 32'(0));
    check("t5_timeouts", 32'(timeout_count), 32'(6));
    exp_q = '{8'h1B, 8'h1B, 8'h1B, 8'h1B};
    compare_sent("t5_byte");
    enable = 1'b0;
    wait_state(ST_IDLE, 10);
    check("t5_fault_cleared", 32'(fault), 32'(0));
    check("t5_frames_kept", 32'(frame_count), 32'(8));
    check("t5_errors_kept", 32'(error_count), 32'(1));
    check("t5_timeouts_kept", 32'(timeout_count), 32'(6));
    sup_all = 1'b0;

    // 6: reset in ECHO, stray echo ignored, then enable dropped mid-frame
    enable = 1'b1;
    wait_state(ST_ECHO, 200);
    reset = 1'b1;
    #1;
    check_all_zero("t6_reset");
    enable = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (30) tick();
    check("t6_stray_errors", 32'(error_count), 32'(0));
    check("t6_stray_busy", 32'(busy), 32'(0));
    sent_q.delete();
    mode = 2'd0;
    enable = 1'b1;
    wait_state(ST_LOAD, 100);
    tick();
    check("t6_start_latency", 32'(uif.start_tx), 32'(1));
    check("t6_first_byte", 32'(uif.data_to_tx), 32'(8'h00));
    wait_sent(2, 200);
    enable = 1'b0;
    wait_state(ST_IDLE, 200);
    check("t6_partial_frames", 32'(frame_count), 32'(0));
    check("t6_partial_errors", 32'(error_count), 32'(0));
    exp_q = '{8'h00, 8'h01};
    compare_sent("t6_byte");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
